spram_arb: RTL and testbench

Single-port BSRAM arbiter for the photo-frame datapath. It shares the one 12-bit image SPRAM between two requesters: the UART pixel-receive path writes a W×H frame sequentially, and the VGA display path reads random addresses. Display reads have priority. Incoming pixels are buffered in a small FIFO so they are not lost while reads hold the port. The block sits between the pixel receiver/display logic and the `spram` primitive.

---
 rtl/spram_arb.sv | 157 +++++++++++++++
 tb/tb_spram_arb.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arb.sv
// spram_arb: shares the single image SPRAM between the pixel writer
// and the display reader. Reads win; pixels wait in a small FIFO.
module spram_arb #(
    parameter int W          = 200,
    parameter int H          = 185,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_full,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_gnt,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_spram_ce,
    output logic              o_spram_wre,
    output logic [ADDR_W-1:0] o_spram_ad,
    output logic [DATA_W-1:0] o_spram_din,
    input  logic [DATA_W-1:0] i_spram_dout,
    output logic [ADDR_W-1:0] o_wr_cnt,
    output logic              o_frame_done,
    output logic              o_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(W * H - 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] wr_addr;
    logic              done;
    logic [RD_LAT:0]   rd_pipe;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic rd_sel;

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign push   = i_wr_valid && !full && !done && !i_frame_start;
    assign rd_sel = i_rd_req && !full && !i_frame_start;
    assign pop    = !i_frame_start && (full || (!i_rd_req && !empty));

    assign o_wr_full = full;
    assign o_rd_gnt  = rd_sel;

    // FIFO storage; contents need no reset, the pointers qualify them
    always_ff @(posedge i_clk_sys) begin
        if (push) begin
            mem[wptr] <= i_wr_data;
        end
    end

    // FIFO pointers and occupancy; a frame start empties it
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (i_frame_start) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // SPRAM command register: one write, one read or idle per cycle
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_spram_ce  <= 1'b0;
            o_spram_wre <= 1'b0;
            o_spram_ad  <= '0;
            o_spram_din <= '0;
        end else if (pop && !done) begin
            o_spram_ce  <= 1'b1;
            o_spram_wre <= 1'b1;
            o_spram_ad  <= wr_addr;
            o_spram_din <= mem[rptr];
        end else if (rd_sel) begin
            o_spram_ce  <= 1'b1;
            o_spram_wre <= 1'b0;
            o_spram_ad  <= i_rd_addr;
        end else begin
            o_spram_ce  <= 1'b0;
            o_spram_wre <= 1'b0;
        end
    end

    // Frame bookkeeping: write address, done, overflow, commit count
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_addr      <= '0;
            done         <= 1'b0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
            o_wr_cnt     <= '0;
        end else if (i_frame_start) begin
            wr_addr      <= '0;
            done         <= 1'b0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
            o_wr_cnt     <= '0;
        end else begin
            o_frame_done <= 1'b0;
            if (i_wr_valid && full && !done) begin
                o_overflow <= 1'b1;
            end
            if (pop && !done) begin
                if (wr_addr == LAST) begin
                    done         <= 1'b1;
                    o_frame_done <= 1'b1;
                end else begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                end
            end
            if (o_spram_wre) begin
                o_wr_cnt <= o_wr_cnt + ADDR_W'(1);
            end
        end
    end

    // Read return pipeline; survives a frame start, cleared by reset
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pipe    <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            rd_pipe    <= {rd_pipe[RD_LAT-1:0], rd_sel};
            o_rd_valid <= rd_pipe[RD_LAT];
            if (rd_pipe[RD_LAT]) begin
                o_rd_data <= i_spram_dout;
            end
        end
    end

endmodule

// File: tb/tb_spram_arb.sv
// tb_spram_arb: directed stimulus with a queue-based reference model
// of the arbiter and a behavioural SPRAM with one cycle read latency.
module tb_spram_arb;

    localparam int NPIX  = 200 * 185;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fs;
    logic        wv;
    logic [11:0] wd;
    logic        rr;
    logic [15:0] ra;
    logic        o_wr_full;
    logic        o_rd_gnt;
    logic [11:0] o_rd_data;
    logic        o_rd_valid;
    logic        o_spram_ce;
    logic        o_spram_wre;
    logic [15:0] o_spram_ad;
    logic [11:0] o_spram_din;
    logic [11:0] sdout;
    logic [15:0] o_wr_cnt;
    logic        o_frame_done;
    logic        o_overflow;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    spram_arb dut (
        .i_clk_sys    (clk),
        .i_rst_n      (rst_n),
        .i_frame_start(fs),
        .i_wr_valid   (wv),
        .i_wr_data    (wd),
        .o_wr_full    (o_wr_full),
        .i_rd_req     (rr),
        .i_rd_addr    (ra),
        .o_rd_gnt     (o_rd_gnt),
        .o_rd_data    (o_rd_data),
        .o_rd_valid   (o_rd_valid),
        .o_spram_ce   (o_spram_ce),
        .o_spram_wre  (o_spram_wre),
        .o_spram_ad   (o_spram_ad),
        .o_spram_din  (o_spram_din),
        .i_spram_dout (sdout),
        .o_wr_cnt     (o_wr_cnt),
        .o_frame_done (o_frame_done),
        .o_overflow   (o_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // behavioural single-port SRAM, registered read
    logic [11:0] sram [65536];
    bit          sinit = 0;
    always @(posedge clk) begin
        if (!sinit) begin
            for (int i = 0; i < 65536; i++) sram[i] = '0;
            sinit = 1;
        end
        if (o_spram_ce) begin
            if (o_spram_wre) sram[o_spram_ad] = o_spram_din;
            else sdout <= sram[o_spram_ad];
        end
    end

    // reference model, evaluated on the falling edge
    typedef struct {
        int          due;
        logic [11:0] d;
    } ret_t;

    ret_t        rq[$];
    logic [11:0] fq[$];
    logic [11:0] img [65536];
    bit          minit = 0;
    int          cyc_n = 0;
    int          waddr;
    bit          mdone;
    bit          movf;
    int          mcnt;
    logic        e_ce, e_wre, e_fd, e_rdv;
    logic [15:0] e_ad;
    logic [11:0] e_din, e_rdd;
    int          fd_count = 0;
    int          fd_ad = 0;
    int          rv_count = 0;

    always @(negedge clk) begin : model
        bit          full_m;
        bit          gnt_m;
        logic [11:0] h;
        if (!minit) begin
            for (int i = 0; i < 65536; i++) img[i] = '0;
            minit = 1;
        end
        cyc_n++;
        if (!rst_n) begin
            chk("rst_ce", o_spram_ce, 0);
            chk("rst_wre", o_spram_wre, 0);
            chk("rst_ad", o_spram_ad, 0);
            chk("rst_din", o_spram_din, 0);
            chk("rst_rdv", o_rd_valid, 0);
            chk("rst_rdd", o_rd_data, 0);
            chk("rst_cnt", o_wr_cnt, 0);
            chk("rst_fd", o_frame_done, 0);
            chk("rst_ovf", o_overflow, 0);
            chk("rst_full", o_wr_full, 0);
            fq.delete();
            rq.delete();
            waddr = 0; mdone = 0; movf = 0; mcnt = 0;
            e_ce = 0; e_wre = 0; e_fd = 0; e_rdv = 0;
            e_ad = '0; e_din = '0; e_rdd = '0;
        end else begin
            full_m = (fq.size() == DEPTH);
            gnt_m  = rr && !full_m && !fs;
            chk("m_ce", o_spram_ce, e_ce);
            chk("m_wre", o_spram_wre, e_wre);
            chk("m_ad", o_spram_ad, e_ad);
            chk("m_din", o_spram_din, e_din);
            chk("m_cnt", o_wr_cnt, mcnt);
            chk("m_fd", o_frame_done, e_fd);
            chk("m_ovf", o_overflow, movf);
            chk("m_rdv", o_rd_valid, e_rdv);
            chk("m_rdd", o_rd_data, e_rdd);
            chk("m_full", o_wr_full, full_m);
            chk("m_gnt", o_rd_gnt, gnt_m);
            if (o_frame_done) begin
                fd_count++;
                fd_ad = int'(o_spram_ad);
            end
            if (o_rd_valid) rv_count++;
            // effects of the command currently on the ports
            if (e_ce && e_wre) img[e_ad] = e_din;
            if (e_ce && !e_wre) rq.push_back('{cyc_n + 2, img[e_ad]});
            if (e_wre) mcnt++;
            e_fd = 0;
            if (rq.size() > 0 && rq[0].due == cyc_n + 1) begin
                e_rdv = 1;
                e_rdd = rq[0].d;
                void'(rq.pop_front());
            end else begin
                e_rdv = 0;
            end
            // arbitration for the coming edge
            if (fs) begin
                fq.delete();
                waddr = 0; mdone = 0; movf = 0; mcnt = 0;
                e_ce = 0; e_wre = 0;
            end else begin
                if (full_m || (!rr && fq.size() > 0)) begin
                    h = fq.pop_front();
                    if (mdone) begin
                        e_ce = 0; e_wre = 0;
                    end else begin
                        e_ce = 1; e_wre = 1;
                        e_ad = 16'(waddr); e_din = h;
                        if (waddr == NPIX - 1) begin
                            e_fd = 1; mdone = 1;
                        end else begin
                            waddr++;
                        end
                    end
                end else if (rr) begin
                    e_ce = 1; e_wre = 0; e_ad = ra;
                end else begin
                    e_ce = 0; e_wre = 0;
                end
                if (wv) begin
                    if (full_m) begin
                        if (!mdone) movf = 1;
                    end else if (!mdone || (e_fd && 0)) begin
                        fq.push_back(wd);
                    end
                end
            end
        end
    end

    initial begin
        int rv0;
        int fd0;
        rst_n = 0; fs = 0; wv = 0; wd = '0; rr = 0; ra = '0;
        repeat (3) cyc();
        chk("reset_ce", o_spram_ce, 0);
        chk("reset_cnt", o_wr_cnt, 0);
        rst_n = 1;
        cyc();

        // isolated write, then read back
        wv = 1; wd = 12'hABC; cyc();
        wv = 0; cyc();
        chk("w1_ce", o_spram_ce, 1);
        chk("w1_wre", o_spram_wre, 1);
        chk("w1_ad", o_spram_ad, 0);
        chk("w1_din", o_spram_din, 12'hABC);
        cyc();
        chk("w1_cnt", o_wr_cnt, 1);
        rr = 1; ra = 16'd0;
        @(negedge clk);
        chk("r1_gnt", o_rd_gnt, 1);
        cyc();
        rr = 0;
        chk("r1_cmd_wre", o_spram_wre, 0);
        chk("r1_cmd_ce", o_spram_ce, 1);
        cyc();
        chk("r1_early", o_rd_valid, 0);
        cyc();
        chk("r1_valid", o_rd_valid, 1);
        chk("r1_data", o_rd_data, 12'hABC);

        // read priority with a filling FIFO
        fs = 1; cyc(); fs = 0;
        chk("pr_cnt0", o_wr_cnt, 0);
        rr = 1; ra = 16'd3; wv = 1;
        for (int i = 0; i < 5; i++) begin
            wd = 12'h101 + 12'(i);
            @(negedge clk);
            chk("pr_gnt", o_rd_gnt, (i != 4));
            chk("pr_full", o_wr_full, (i == 4));
            cyc();
        end
        wv = 0;
        chk("pr_ovf", o_overflow, 1);
        chk("pr_wre", o_spram_wre, 1);
        chk("pr_ad", o_spram_ad, 0);
        chk("pr_din", o_spram_din, 12'h101);
        @(negedge clk);
        chk("pr_gnt_back", o_rd_gnt, 1);
        repeat (5) cyc();
        chk("pr_cnt1", o_wr_cnt, 1);
        rr = 0;
        repeat (8) cyc();
        chk("pr_cnt4", o_wr_cnt, 4);

        // reset with 3 queued pixels and reads in flight
        rr = 1; ra = 16'd1; wv = 1;
        for (int i = 0; i < 3; i++) begin
            wd = 12'h301 + 12'(i);
            cyc();
        end
        wv = 0; rr = 0; rst_n = 0;
        #1;
        chk("mr_ce", o_spram_ce, 0);
        chk("mr_ad", o_spram_ad, 0);
        chk("mr_din", o_spram_din, 0);
        chk("mr_ovf", o_overflow, 0);
        chk("mr_cnt", o_wr_cnt, 0);
        chk("mr_full", o_wr_full, 0);
        cyc(); cyc();
        rst_n = 1;
        rv0 = rv_count;
        repeat (6) cyc();
        chk("mr_no_rdv", rv_count - rv0, 0);
        chk("mr_no_wr", o_wr_cnt, 0);

        // full frame at one pixel per cycle
        fd0 = fd_count;
        wv = 1;
        for (int i = 0; i < NPIX; i++) begin
            wd = 12'(i);
            cyc();
        end
        wv = 0;
        repeat (5) cyc();
        chk("ff_cnt", o_wr_cnt, 37000);
        chk("ff_done_pulses", fd_count - fd0, 1);
        chk("ff_done_ad", fd_ad, 36999);
        wv = 1; wd = 12'h777; cyc();
        wv = 0;
        repeat (4) cyc();
        chk("ff_extra_cnt", o_wr_cnt, 37000);
        chk("ff_extra_ovf", o_overflow, 0);

        // back-to-back reads
        rr = 1; ra = 16'd5; cyc();
        ra = 16'd6; cyc();
        ra = 16'd7; cyc();
        rr = 0;
        chk("bb_v0", o_rd_valid, 1);
        chk("bb_d0", o_rd_data, 12'd5);
        cyc();
        chk("bb_v1", o_rd_valid, 1);
        chk("bb_d1", o_rd_data, 12'd6);
        cyc();
        chk("bb_v2", o_rd_valid, 1);
        chk("bb_d2", o_rd_data, 12'd7);
        cyc();
        chk("bb_v3", o_rd_valid, 0);

        // frame restart with queued pixels and reads in flight
        fs = 1; cyc(); fs = 0;
        rr = 1; ra = 16'd5; wv = 1; wd = 12'h201; cyc();
        wd = 12'h202; cyc();
        rr = 0; fs = 1; wd = 12'hEEE; cyc();
        fs = 0; wv = 0;
        chk("rs_cnt", o_wr_cnt, 0);
        chk("rs_ovf", o_overflow, 0);
        chk("rs_full", o_wr_full, 0);
        chk("rs_v0", o_rd_valid, 1);
        chk("rs_d0", o_rd_data, 12'd5);
        cyc();
        chk("rs_v1", o_rd_valid, 1);
        chk("rs_d1", o_rd_data, 12'd5);
        chk("rs_flushed", o_spram_ce, 0);
        cyc();
        wv = 1; wd = 12'h333; cyc();
        wv = 0; cyc();
        chk("rs_wre", o_spram_wre, 1);
        chk("rs_ad", o_spram_ad, 0);
        chk("rs_din", o_spram_din, 12'h333);
        cyc();
        chk("rs_cnt1", o_wr_cnt, 1);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
